mem_bus_arbiter: RTL and testbench

- Arbitrates the single shared byte-wide memory/IO bus between the instruction shim (read-only) and the data shim (read/write).
- Replaces the current combinational RAM-use merge and the double-driven address bus with one registered owner.
- Sequences each byte access: issue, wait for the fixed block-RAM latency, capture read data, then acknowledge the requester.
- Sits between both shims and the kbyte-decoded I_ROM, Data_RAM and IO address space.

---
 rtl/mem_arb_pkg.sv | 30 +++
 rtl/mem_bus_arbiter_if.sv | 47 ++++
 rtl/mem_arb_lat_ctr.sv | 38 +++
 rtl/mem_bus_arbiter.sv | 239 +++++++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// ============================================================================
// Module : mem_arb_pkg
// Brief  : Shared types and defaults for the memory bus arbiter slice.
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        ACK    = 2'd3
    } arb_state_t;

    typedef enum logic [1:0] {
        OWNER_NONE = 2'd0,
        OWNER_I    = 2'd1,
        OWNER_D    = 2'd2
    } owner_t;

    localparam int c_READ_LAT_DEF = 2;
    // Latency counter width covers the full legal READ_LAT range of 1..7.
    localparam int c_LAT_W        = 3;

endpackage

`default_nettype wire

// File: rtl/mem_bus_arbiter_if.sv
// ============================================================================
// Module : mem_bus_arbiter_if
// Brief  : Requester handshakes and shared byte bus seen by the arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface mem_bus_arbiter_if #(
    parameter int ADDR_W = 32
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              d_req;
    logic [ADDR_W-1:0] d_addr;
    logic              d_write;
    logic [7:0]        d_wdata;
    logic [7:0]        bus_rdata;

    logic              i_gnt;
    logic              d_gnt;
    logic              i_ack;
    logic [7:0]        i_rdata;
    logic              d_ack;
    logic [7:0]        d_rdata;
    logic              bus_use;
    logic              bus_read;
    logic              bus_write;
    logic [ADDR_W-1:0] bus_addr;
    logic [7:0]        bus_wdata;

    // Arbiter side
    modport slave (
        input  i_req, i_addr, d_req, d_addr, d_write, d_wdata, bus_rdata,
        output i_gnt, d_gnt, i_ack, i_rdata, d_ack, d_rdata,
               bus_use, bus_read, bus_write, bus_addr, bus_wdata
    );

    // Shims plus memory side
    modport master (
        output i_req, i_addr, d_req, d_addr, d_write, d_wdata, bus_rdata,
        input  i_gnt, d_gnt, i_ack, i_rdata, d_ack, d_rdata,
               bus_use, bus_read, bus_write, bus_addr, bus_wdata
    );
endinterface

`default_nettype wire

// File: rtl/mem_arb_lat_ctr.sv
// ============================================================================
// Module : mem_arb_lat_ctr
// Brief  : Loadable saturating down-counter with a zero flag.
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module mem_arb_lat_ctr
    import mem_arb_pkg::*;
#(
    parameter int WIDTH = c_LAT_W
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             load,
    input  wire logic [WIDTH-1:0] load_val,
    input  wire logic             dec,
    output logic                  zero
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign zero = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
// ============================================================================
// Module : mem_bus_arbiter
// Brief  : Round-robin owner of the shared byte bus for the I and D shims.
//          Optional MEM_ARB_BURST_LIMIT_EN forces handover after MAX_BURST
//          bytes when the other side is waiting.
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int READ_LAT  = c_READ_LAT_DEF,
    parameter int MAX_BURST = 6
) (
    input  wire logic          clk,
    input  wire logic          reset,
    mem_bus_arbiter_if.slave   bus
);

    localparam logic [c_LAT_W-1:0] c_LAT_LOAD = c_LAT_W'(READ_LAT - 1);

    if ((READ_LAT < 1) || (READ_LAT > 7) || (MAX_BURST < 1)) begin : g_param_check
        $error("mem_bus_arbiter: READ_LAT must be 1..7 and MAX_BURST at least 1");
    end

    arb_state_t        r_state,      w_state_nxt;
    owner_t            r_owner,      w_owner_nxt;
    owner_t            r_last_owner, w_last_owner_nxt;
    logic              r_i_gnt,      w_i_gnt_nxt;
    logic              r_d_gnt,      w_d_gnt_nxt;
    logic              r_i_ack,      w_i_ack_nxt;
    logic              r_d_ack,      w_d_ack_nxt;
    logic [7:0]        r_i_rdata,    w_i_rdata_nxt;
    logic [7:0]        r_d_rdata,    w_d_rdata_nxt;
    logic              r_bus_use,    w_bus_use_nxt;
    logic              r_bus_read,   w_bus_read_nxt;
    logic              r_bus_write,  w_bus_write_nxt;
    logic [ADDR_W-1:0] r_bus_addr,   w_bus_addr_nxt;
    logic [7:0]        r_bus_wdata,  w_bus_wdata_nxt;

    logic   w_grant_i;
    logic   w_grant_d;
    logic   w_owner_req;
    logic   w_burst_stop;
    logic   w_issue;
    owner_t w_issue_owner;
    logic   w_lat_load;
    logic   w_lat_dec;
    logic   w_lat_zero;

    // Round-robin: on contention the side that did not own the bus last wins.
    assign w_grant_i   = bus.i_req && (!bus.d_req || (r_last_owner == OWNER_D));
    assign w_grant_d   = bus.d_req && !w_grant_i;
    assign w_owner_req = ((r_owner == OWNER_I) && bus.i_req) ||
                         ((r_owner == OWNER_D) && bus.d_req);

    mem_arb_lat_ctr #(
        .WIDTH (c_LAT_W)
    ) u_lat_ctr (
        .clk      (clk),
        .reset    (reset),
        .load     (w_lat_load),
        .load_val (c_LAT_LOAD),
        .dec      (w_lat_dec),
        .zero     (w_lat_zero)
    );

`ifdef MEM_ARB_BURST_LIMIT_EN
    localparam int c_BURST_W = $clog2(MAX_BURST + 1);
    localparam logic [c_BURST_W-1:0] c_BURST_LOAD = c_BURST_W'(MAX_BURST - 1);

    logic w_rival_req;
    logic w_burst_load;
    logic w_burst_dec;
    logic w_burst_zero;

    assign w_rival_req  = ((r_owner == OWNER_I) && bus.d_req) ||
                          ((r_owner == OWNER_D) && bus.i_req);
    // Counter reaches zero on the MAX_BURST-th ACK and then saturates.
    assign w_burst_load = (r_state == IDLE) && (w_grant_i || w_grant_d);
    assign w_burst_dec  = (r_state == ACK);
    assign w_burst_stop = w_burst_zero && w_rival_req;

    mem_arb_lat_ctr #(
        .WIDTH (c_BURST_W)
    ) u_burst_ctr (
        .clk      (clk),
        .reset    (reset),
        .load     (w_burst_load),
        .load_val (c_BURST_LOAD),
        .dec      (w_burst_dec),
        .zero     (w_burst_zero)
    );
`else
    assign w_burst_stop = 1'b0;
`endif

    always_comb begin
        w_state_nxt      = r_state;
        w_owner_nxt      = r_owner;
        w_last_owner_nxt = r_last_owner;
        w_i_gnt_nxt      = r_i_gnt;
        w_d_gnt_nxt      = r_d_gnt;
        w_i_ack_nxt      = 1'b0;
        w_d_ack_nxt      = 1'b0;
        w_i_rdata_nxt    = r_i_rdata;
        w_d_rdata_nxt    = r_d_rdata;
        w_bus_use_nxt    = r_bus_use;
        w_bus_read_nxt   = r_bus_read;
        w_bus_write_nxt  = r_bus_write;
        w_bus_addr_nxt   = r_bus_addr;
        w_bus_wdata_nxt  = r_bus_wdata;
        w_issue          = 1'b0;
        w_issue_owner    = OWNER_NONE;
        w_lat_load       = 1'b0;
        w_lat_dec        = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_grant_i || w_grant_d) begin
                    w_issue       = 1'b1;
                    w_issue_owner = w_grant_i ? OWNER_I : OWNER_D;
                    w_owner_nxt   = w_issue_owner;
                    w_i_gnt_nxt   = w_grant_i;
                    w_d_gnt_nxt   = w_grant_d;
                    w_state_nxt   = ACCESS;
                end
            end

            ACCESS, WAIT: begin
                if (w_lat_zero) begin
                    // Data is sampled on the edge that enters ACK.
                    w_state_nxt     = ACK;
                    w_bus_use_nxt   = 1'b0;
                    w_bus_read_nxt  = 1'b0;
                    w_bus_write_nxt = 1'b0;
                    if (r_owner == OWNER_I) begin
                        w_i_ack_nxt   = 1'b1;
                        w_i_rdata_nxt = bus.bus_rdata;
                    end else begin
                        w_d_ack_nxt = 1'b1;
                        if (!r_bus_write) begin
                            w_d_rdata_nxt = bus.bus_rdata;
                        end
                    end
                end else begin
                    w_lat_dec   = 1'b1;
                    w_state_nxt = WAIT;
                end
            end

            ACK: begin
                if (w_owner_req && !w_burst_stop) begin
                    w_issue       = 1'b1;
                    w_issue_owner = r_owner;
                    w_state_nxt   = ACCESS;
                end else begin
                    w_state_nxt      = IDLE;
                    w_owner_nxt      = OWNER_NONE;
                    w_last_owner_nxt = r_owner;
                    w_i_gnt_nxt      = 1'b0;
                    w_d_gnt_nxt      = 1'b0;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // Shared by the first byte of a grant and each following burst byte.
        if (w_issue) begin
            w_lat_load    = 1'b1;
            w_bus_use_nxt = 1'b1;
            if (w_issue_owner == OWNER_I) begin
                w_bus_addr_nxt  = bus.i_addr;
                w_bus_read_nxt  = 1'b1;
                w_bus_write_nxt = 1'b0;
            end else begin
                w_bus_addr_nxt  = bus.d_addr;
                w_bus_wdata_nxt = bus.d_wdata;
                w_bus_read_nxt  = !bus.d_write;
                w_bus_write_nxt = bus.d_write;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_owner      <= OWNER_NONE;
            r_last_owner <= OWNER_D;
            r_i_gnt      <= 1'b0;
            r_d_gnt      <= 1'b0;
            r_i_ack      <= 1'b0;
            r_d_ack      <= 1'b0;
            r_i_rdata    <= 8'h00;
            r_d_rdata    <= 8'h00;
            r_bus_use    <= 1'b0;
            r_bus_read   <= 1'b0;
            r_bus_write  <= 1'b0;
            r_bus_addr   <= '0;
            r_bus_wdata  <= 8'h00;
        end else begin
            r_state      <= w_state_nxt;
            r_owner      <= w_owner_nxt;
            r_last_owner <= w_last_owner_nxt;
            r_i_gnt      <= w_i_gnt_nxt;
            r_d_gnt      <= w_d_gnt_nxt;
            r_i_ack      <= w_i_ack_nxt;
            r_d_ack      <= w_d_ack_nxt;
            r_i_rdata    <= w_i_rdata_nxt;
            r_d_rdata    <= w_d_rdata_nxt;
            r_bus_use    <= w_bus_use_nxt;
            r_bus_read   <= w_bus_read_nxt;
            r_bus_write  <= w_bus_write_nxt;
            r_bus_addr   <= w_bus_addr_nxt;
            r_bus_wdata  <= w_bus_wdata_nxt;
        end
    end

    assign bus.i_gnt     = r_i_gnt;
    assign bus.d_gnt     = r_d_gnt;
    assign bus.i_ack     = r_i_ack;
    assign bus.d_ack     = r_d_ack;
    assign bus.i_rdata   = r_i_rdata;
    assign bus.d_rdata   = r_d_rdata;
    assign bus.bus_use   = r_bus_use;
    assign bus.bus_read  = r_bus_read;
    assign bus.bus_write = r_bus_write;
    assign bus.bus_addr  = r_bus_addr;
    assign bus.bus_wdata = r_bus_wdata;

endmodule

`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
// ============================================================================
// Module : tb_mem_bus_arbiter
// Brief  : Scoreboard bench for mem_bus_arbiter (READ_LAT = 2).
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mem_bus_arbiter;
    import mem_arb_pkg::*;

    localparam int ADDR_W    = 32;
    localparam int READ_LAT  = 2;
    localparam int MAX_BURST = 6;

    typedef struct {
        logic        is_d;
        logic        wr;
        logic [31:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  rdata;
    } exp_t;

    logic clk_50MHz = 1'b0;
    logic reset     = 1'b1;
    int   n_checks  = 0;
    int   n_fail    = 0;
    exp_t q_issue[$];
    exp_t q_ack[$];
    logic [7:0] model_d_rdata = 8'h00;

    logic        prev_use = 1'b0;
    logic        prev_i_gnt = 1'b0;
    logic        prev_d_gnt = 1'b0;
    logic [33:0] prev_bus = '0;

    always #10 clk_50MHz = ~clk_50MHz;

    mem_bus_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

    mem_bus_arbiter #(
        .ADDR_W    (ADDR_W),
        .READ_LAT  (READ_LAT),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk   (clk_50MHz),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic [7:0] rd_model(input logic [31:0] a);
        return a[7:0] + 8'h20;
    endfunction

    // Synchronous-read memory: address seen in the issue cycle, data one edge later.
    always @(posedge clk_50MHz) bus.bus_rdata <= rd_model(bus.bus_addr);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    task automatic chk_all_zero(input string name);
        chk(name, {bus.i_gnt, bus.d_gnt, bus.i_ack, bus.d_ack, bus.bus_use,
                   bus.bus_read, bus.bus_write, bus.i_rdata, bus.d_rdata,
                   bus.bus_wdata, bus.bus_addr}, 64'h0);
    endtask

    task automatic push_exp(input logic is_d, input logic wr, input logic [31:0] addr,
                            input logic [7:0] wdata);
        exp_t e;
        e.is_d  = is_d;
        e.wr    = wr;
        e.addr  = addr;
        e.wdata = wdata;
        if (is_d && wr) e.rdata = model_d_rdata;
        else            e.rdata = rd_model(addr);
        if (is_d && !wr) model_d_rdata = e.rdata;
        q_issue.push_back(e);
        q_ack.push_back(e);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.i_req = 1'b0; bus.i_addr = '0;
        bus.d_req = 1'b0; bus.d_addr = '0; bus.d_write = 1'b0; bus.d_wdata = 8'h00;
        q_issue.delete();
        q_ack.delete();
        model_d_rdata = 8'h00;
        repeat (2) @(negedge clk_50MHz);
        chk_all_zero("reset_values");
        reset = 1'b0;
        @(negedge clk_50MHz);
    endtask

    task automatic run_i(input int n, input logic [31:0] base);
        bus.i_addr = base;
        bus.i_req  = 1'b1;
        for (int k = 0; k < n; k++) begin
            int t = 0;
            do begin
                @(negedge clk_50MHz);
                t++;
            end while (!bus.i_ack && t < 100);
            if (!bus.i_ack) begin
                fail_now("i_ack_timeout");
                bus.i_req = 1'b0;
                return;
            end
            if (k == n - 1) bus.i_req = 1'b0;
            else            bus.i_addr = base + 32'(k + 1);
        end
    endtask

    task automatic run_d(input int n, input logic [31:0] base, input logic wr,
                         input logic [7:0] wbase);
        bus.d_addr  = base;
        bus.d_write = wr;
        bus.d_wdata = wbase;
        bus.d_req   = 1'b1;
        for (int k = 0; k < n; k++) begin
            int t = 0;
            do begin
                @(negedge clk_50MHz);
                t++;
            end while (!bus.d_ack && t < 100);
            if (!bus.d_ack) begin
                fail_now("d_ack_timeout");
                bus.d_req = 1'b0;
                return;
            end
            if (k == n - 1) begin
                bus.d_req = 1'b0;
            end else begin
                bus.d_addr  = base + 32'(k + 1);
                bus.d_wdata = wbase + 8'(k + 1);
            end
        end
    endtask

    // Monitor: bus issue and ack checks against the scoreboard queues.
    always @(negedge clk_50MHz) begin
        if (reset) begin
            prev_use   <= 1'b0;
            prev_i_gnt <= 1'b0;
            prev_d_gnt <= 1'b0;
            prev_bus   <= '0;
        end else begin
            exp_t e;
            chk("gnt_exclusive", 64'(bus.i_gnt & bus.d_gnt), 64'h0);
            chk("strobe_exclusive", 64'(bus.bus_read & bus.bus_write), 64'h0);
            if ((bus.i_gnt && !prev_i_gnt) || (bus.d_gnt && !prev_d_gnt))
                chk("turnaround_idle", {61'h0, prev_i_gnt, prev_d_gnt, prev_use}, 64'h0);
            if (bus.bus_use && prev_use)
                chk("bus_stable", {30'h0, bus.bus_read, bus.bus_write, bus.bus_addr},
                    {30'h0, prev_bus});
            if (bus.bus_use && !prev_use) begin
                if (q_issue.size() == 0) begin
                    fail_now("issue_unexpected");
                end else begin
                    e = q_issue.pop_front();
                    chk("issue_addr", 64'(bus.bus_addr), 64'(e.addr));
                    chk("issue_rw", {62'h0, bus.bus_read, bus.bus_write}, {62'h0, !e.wr, e.wr});
                    chk("issue_gnt", {62'h0, bus.i_gnt, bus.d_gnt}, {62'h0, !e.is_d, e.is_d});
                    if (e.wr) chk("issue_wdata", 64'(bus.bus_wdata), 64'(e.wdata));
                end
            end
            if (bus.i_ack || bus.d_ack) begin
                if (q_ack.size() == 0) begin
                    fail_now("ack_unexpected");
                end else begin
                    e = q_ack.pop_front();
                    chk("ack_owner", {62'h0, bus.i_ack, bus.d_ack}, {62'h0, !e.is_d, e.is_d});
                    chk("ack_rdata", 64'(e.is_d ? bus.d_rdata : bus.i_rdata), 64'(e.rdata));
                end
            end
            prev_use   <= bus.bus_use;
            prev_i_gnt <= bus.i_gnt;
            prev_d_gnt <= bus.d_gnt;
            prev_bus   <= {bus.bus_read, bus.bus_write, bus.bus_addr};
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();

        // Single I read with cycle-exact timing; address change mid-byte is ignored.
        push_exp(1'b0, 1'b0, 32'h10, 8'h00);
        bus.i_addr = 32'h10;
        bus.i_req  = 1'b1;
        @(negedge clk_50MHz);
        chk("c1_gnt_read_addr", {bus.i_gnt, bus.bus_read, bus.i_ack, bus.bus_addr},
            {1'b1, 1'b1, 1'b0, 32'h10});
        bus.i_addr = 32'h55;
        @(negedge clk_50MHz);
        chk("c2_read_no_ack", {bus.bus_read, bus.i_ack, bus.bus_addr}, {1'b1, 1'b0, 32'h10});
        @(negedge clk_50MHz);
        chk("c3_ack_rdata", {bus.i_ack, bus.bus_read, bus.i_rdata}, {1'b1, 1'b0, 8'h30});
        bus.i_req = 1'b0;
        @(negedge clk_50MHz);
        chk("c4_release", {bus.i_gnt, bus.bus_use}, 64'h0);

        // D write, D read, D write: writes must leave d_rdata alone.
        push_exp(1'b1, 1'b1, 32'hF004, 8'hA5);
        run_d(1, 32'hF004, 1'b1, 8'hA5);
        @(negedge clk_50MHz);
        push_exp(1'b1, 1'b0, 32'h44, 8'h00);
        run_d(1, 32'h44, 1'b0, 8'h00);
        @(negedge clk_50MHz);
        push_exp(1'b1, 1'b1, 32'h08, 8'h11);
        run_d(1, 32'h08, 1'b1, 8'h11);
        repeat (2) @(negedge clk_50MHz);

        // Contention right after reset: I first (6 bytes), then D.
        do_reset();
        for (int k = 0; k < 6; k++) push_exp(1'b0, 1'b0, 32'h100 + 32'(k), 8'h00);
        for (int k = 0; k < 2; k++) push_exp(1'b1, 1'b0, 32'h200 + 32'(k), 8'h00);
        fork
            run_i(6, 32'h100);
            run_d(2, 32'h200, 1'b0, 8'h00);
        join
        repeat (2) @(negedge clk_50MHz);

        // D holds req for 10 bytes while I waits.
        do_reset();
`ifdef MEM_ARB_BURST_LIMIT_EN
        for (int k = 0; k < 6; k++)  push_exp(1'b1, 1'b0, 32'h300 + 32'(k), 8'h00);
        for (int k = 0; k < 2; k++)  push_exp(1'b0, 1'b0, 32'h400 + 32'(k), 8'h00);
        for (int k = 6; k < 10; k++) push_exp(1'b1, 1'b0, 32'h300 + 32'(k), 8'h00);
`else
        for (int k = 0; k < 10; k++) push_exp(1'b1, 1'b0, 32'h300 + 32'(k), 8'h00);
        for (int k = 0; k < 2; k++)  push_exp(1'b0, 1'b0, 32'h400 + 32'(k), 8'h00);
`endif
        fork
            run_d(10, 32'h300, 1'b0, 8'h00);
            begin
                @(negedge clk_50MHz);
                run_i(2, 32'h400);
            end
        join
        repeat (2) @(negedge clk_50MHz);

        // Reset asserted during WAIT clears everything at once.
        push_exp(1'b0, 1'b0, 32'h20, 8'h00);
        bus.i_addr = 32'h20;
        bus.i_req  = 1'b1;
        repeat (2) @(negedge clk_50MHz);
        chk("wait_bus_read", {bus.bus_use, bus.bus_read, bus.i_ack}, {1'b1, 1'b1, 1'b0});
        reset = 1'b1;
        #1;
        chk_all_zero("async_reset_mid_access");
        q_issue.delete();
        q_ack.delete();
        repeat (2) @(negedge clk_50MHz);
        push_exp(1'b0, 1'b0, 32'h21, 8'h00);
        bus.i_addr = 32'h21;
        reset = 1'b0;
        @(negedge clk_50MHz);
        chk("post_reset_grant", {bus.i_gnt, bus.i_ack, bus.bus_read}, {1'b1, 1'b0, 1'b1});
        run_i(1, 32'h21);
        repeat (2) @(negedge clk_50MHz);

        // I drops req in the cycle after ACCESS: byte still completes.
        push_exp(1'b0, 1'b0, 32'h7F, 8'h00);
        bus.i_addr = 32'h7F;
        bus.i_req  = 1'b1;
        repeat (2) @(negedge clk_50MHz);
        bus.i_req = 1'b0;
        @(negedge clk_50MHz);
        chk("drop_ack", {bus.i_ack, bus.i_gnt, bus.i_rdata}, {1'b1, 1'b1, 8'h9F});
        @(negedge clk_50MHz);
        chk("drop_idle", {bus.i_ack, bus.i_gnt, bus.bus_use}, 64'h0);

        repeat (4) @(negedge clk_50MHz);
        chk("issue_queue_empty", 64'(q_issue.size()), 64'h0);
        chk("ack_queue_empty", 64'(q_ack.size()), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
